// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels, common to the transmitter and
// receiver.
package uart_pkg;

  localparam logic [2:0] StateIdle   = 3'd0;
  localparam logic [2:0] StateWait   = 3'd1;
  localparam logic [2:0] StateStart  = 3'd2;
  localparam logic [2:0] StateData   = 3'd3;
  localparam logic [2:0] StateParity = 3'd4;
  localparam logic [2:0] StateStop   = 3'd5;

  typedef enum logic [2:0] {
    StIdle   = StateIdle,
    StWait   = StateWait,
    StStart  = StateStart,
    StData   = StateData,
    StParity = StateParity,
    StStop   = StateStop
  } uart_state_e;

  localparam logic IdleLevel  = 1'b1;
  localparam logic StartLevel = 1'b0;
  localparam logic StopLevel  = 1'b1;

  // Narrower characters are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_edge_detect.sv
// Rising-edge detector: registers the input and flags the cycle in which it goes 0 -> 1.
module uart_edge_detect (
  input  logic clk,
  input  logic arst_n,
  input  logic sig,
  output logic tick
);

  logic sig_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign tick = sig & ~sig_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames bytes as start/data/[parity]/stop on tx, paced by the baud square wave.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(DATA_BITS);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 tx_q;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  uart_edge_detect u_baud_edge (
    .clk    (clk),
    .arst_n (arst_n),
    .sig    (baud_in),
    .tick   (tick)
  );

  assign tx       = tx_q;
  assign tx_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= IdleLevel;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= IdleLevel;
          // A tick coinciding with accept is deliberately not used; WAIT takes the next one.
          if (tx_valid) begin
            shreg_q    <= tx_data;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= even_parity(8'(tx_data));
`endif
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (tick) begin
            tx_q    <= StartLevel;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            tx_q      <= shreg_q[0];
            bit_cnt_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (bit_cnt_q == CntW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_q       <= parity_q;
              state_q    <= StParity;
`else
              tx_q       <= StopLevel;
              stop_cnt_q <= 1'b0;
              state_q    <= StStop;
`endif
            end else begin
              shreg_q   <= shreg_q >> 1;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              tx_q      <= shreg_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (tick) begin
            tx_q       <= StopLevel;
            stop_cnt_q <= 1'b0;
            state_q    <= StStop;
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              tx_q    <= IdleLevel;
              state_q <= StIdle;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= IdleLevel;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: baud_in toggles every 4 clocks (8-clock bit period); line bits are
// sampled mid-bit and compared with hand-computed frames.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       baud_in = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int baud_cnt = 0;

`ifdef UART_TX_PARITY_EN
  localparam int         NBits = 11;
  localparam logic [11:0] FrA5 = 12'b0101_0100_1010;
  localparam logic [11:0] Fr3C = 12'b0100_0111_1000;
  localparam logic [11:0] Fr81 = 12'b0101_0000_0010;
  localparam logic [11:0] Fr0F = 12'b0100_0001_1110;
`else
  localparam int         NBits = 10;
  localparam logic [11:0] FrA5 = 12'b0011_0100_1010;
  localparam logic [11:0] Fr3C = 12'b0010_0111_1000;
  localparam logic [11:0] Fr81 = 12'b0011_0000_0010;
  localparam logic [11:0] Fr0F = 12'b0010_0001_1110;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
    int          nbits;
  } vec_t;

  vec_t vecs[4];

  uart_tx #(
    .DATA_BITS (8),
    .STOP_BITS (1)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .baud_in  (baud_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Free-running bit clock, changed away from the active edge.
  always @(negedge clk) begin
    if (baud_cnt == 3) begin
      baud_cnt <= 0;
      baud_in  <= ~baud_in;
    end else begin
      baud_cnt <= baud_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle valid pulse issued while idle; busy/ready must flip the cycle after accept.
  task automatic send_pulse(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_ready_low", 32'(tx_ready), 32'd0);
  endtask

  task automatic wait_start(input string name, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    check({name, "_start_seen"}, 32'(found), 32'd1);
  endtask

  // Returns at the middle of the last stop bit.
  task automatic check_frame(input string name, input logic [11:0] exp, input int nbits);
    bit found;
    wait_start(name, found);
    if (found) begin
      step(4);
      for (int b = 0; b < nbits; b++) begin
        check($sformatf("%s_bit%0d", name, b), 32'(tx), 32'(exp[b]));
        check($sformatf("%s_ready%0d", name, b), 32'(tx_ready), 32'd0);
        if (b != nbits - 1) step(8);
      end
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_ready"}, 32'(tx_ready), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_tx"}, 32'(tx), 32'd1);
  endtask

  task automatic reset_mid_frame(input logic [7:0] d, input logic exp_bit, input string name);
    bit found;
    send_pulse(d);
    wait_start(name, found);
    step(4 + 8 * 5);
    check({name, "_bit_before"}, 32'(tx), 32'(exp_bit));
    #1 arst_n = 1'b0;
    #1;
    check({name, "_tx_async"}, 32'(tx), 32'd1);
    check({name, "_busy_async"}, 32'(busy), 32'd0);
    check({name, "_ready_async"}, 32'(tx_ready), 32'd1);
    step(2);
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{data: 8'h07, frame: 12'b0110_0000_1110, nbits: 11};
    vecs[1] = '{data: 8'h03, frame: 12'b0100_0000_0110, nbits: 11};
    vecs[2] = '{data: 8'h55, frame: 12'b0100_1010_1010, nbits: 11};
    vecs[3] = '{data: 8'hFF, frame: 12'b0101_1111_1110, nbits: 11};
`else
    vecs[0] = '{data: 8'h55, frame: 12'b0010_1010_1010, nbits: 10};
    vecs[1] = '{data: 8'h0F, frame: 12'b0010_0001_1110, nbits: 10};
    vecs[2] = '{data: 8'h00, frame: 12'b0010_0000_0000, nbits: 10};
    vecs[3] = '{data: 8'hFF, frame: 12'b0011_1111_1110, nbits: 10};
`endif

    // Reset values, then quiet line after release.
    step(3);
    check_idle("reset");
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(8);
      check_idle($sformatf("post_reset%0d", i));
    end

    // Table of single frames.
    for (int v = 0; v < 4; v++) begin
      send_pulse(vecs[v].data);
      check_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].nbits);
      step(4);
      check_idle($sformatf("vec%0d_end", v));
    end

    // Back-to-back with tx_valid held high.
    begin
      bit seen_idle = 1'b0;
      @(negedge clk);
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      check("b2b_first_busy", 32'(busy), 32'd1);
      tx_data = 8'h3C;
      check_frame("b2b_a5", FrA5, NBits);
      for (int i = 0; i < 20 && !seen_idle; i++) begin
        if (tx_ready === 1'b1) seen_idle = 1'b1;
        else @(negedge clk);
      end
      check("b2b_ready_returns", 32'(seen_idle), 32'd1);
      @(negedge clk);
      check("b2b_second_accept", 32'(busy), 32'd1);
      tx_valid = 1'b0;
      check_frame("b2b_3c", Fr3C, NBits);
      step(4);
      check_idle("b2b_end");
    end

    // Reset during data bit 4, then a clean frame.
    reset_mid_frame(8'h00, 1'b0, "rst_00");
    reset_mid_frame(8'hFF, 1'b1, "rst_ff");
    step(4);
    check_idle("rst_recover");
    send_pulse(8'h0F);
    check_frame("after_rst_0f", Fr0F, NBits);
    step(4);
    check_idle("after_rst_end");

    // New data and valid while busy are ignored.
    send_pulse(8'h81);
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("ignore_ready", 32'(tx_ready), 32'd0);
    check_frame("ignore_81", Fr81, NBits);
    step(4);
    check_idle("ignore_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
